// File: rtl/mul_const_arbiter.sv
// -----------------------------------------------------------------------------
// mul_const_arbiter
//   Shares one external mul_const fixed-point multiplier (Q8.40) among N_REQ
//   requesters. A round-robin pointer picks the winner in IDLE. The winner's
//   operand pair is latched onto mul_inp/mul_const_in and mul_arm is raised.
//   When the multiplier reports mul_finished, the product is captured into
//   res and a one-cycle one-hot done pulse goes to the winner. The FSM then
//   waits in CLR for mul_finished to fall before the next grant.
//
// Handshake: mul_arm is a level request to the multiplier. It stays high,
//   with the operands held stable, until mul_finished is seen high. mul_arm
//   then drops and the multiplier must lower mul_finished before a new arm
//   is issued. Dropping mul_arm at any other time (reset, watchdog) aborts the
//   multiplier.
//
// Ports
//   clk, rst_L        clock, asynchronous active-low reset
//   req               per-requester level request
//   inp_flat          operand i at [i*IN_WID +: IN_WID]
//   const_flat        constant i at [i*CONSTS_WID +: CONSTS_WID]
//   done              one-cycle one-hot completion pulse
//   res               product, valid while done != 0, held afterwards
//   grant_idx         index of the current or last winner
//   busy              high whenever the FSM is not in IDLE
//   mul_inp           registered operand to mul_const.inp
//   mul_const_in      registered constant to mul_const.const_in
//   mul_arm           arm request to mul_const
//   mul_outp          product from mul_const
//   mul_finished      completion level from mul_const
//   timeout_err       sticky watchdog flag (tied 0 without the watchdog)
//   state_dbg         current FSM state (0 IDLE, 1 ARM, 2 CLR)
//
// Configuration
//   MUL_ARB_TIMEOUT_EN : when defined, a 16-bit watchdog aborts an ARM phase
//                        that lasts TIMEOUT_CYC cycles without mul_finished.
// -----------------------------------------------------------------------------
module mul_const_arbiter #(
  parameter int N_REQ       = 3,
  parameter int GRANT_WID   = 2,
  parameter int CONSTS_WID  = 48,
  parameter int IN_WID      = 48,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst_L,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*IN_WID-1:0]     inp_flat,
  input  logic [N_REQ*CONSTS_WID-1:0] const_flat,
  output logic [N_REQ-1:0]            done,
  output logic [CONSTS_WID-1:0]       res,
  output logic [GRANT_WID-1:0]        grant_idx,
  output logic                        busy,
  output logic [IN_WID-1:0]           mul_inp,
  output logic [CONSTS_WID-1:0]       mul_const_in,
  output logic                        mul_arm,
  input  logic [CONSTS_WID-1:0]       mul_outp,
  input  logic                        mul_finished,
  output logic                        timeout_err,
  output logic [1:0]                  state_dbg
);

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("mul_const_arbiter: N_REQ must be 2..8");
  end
  if ((1 << GRANT_WID) < N_REQ) begin : g_bad_gwid
    $error("mul_const_arbiter: GRANT_WID too small for N_REQ");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
    $error("mul_const_arbiter: TIMEOUT_CYC must be 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CLR  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [GRANT_WID-1:0]    ptr_q;
  logic [GRANT_WID-1:0]    grant_q;
  logic [N_REQ-1:0]        done_q;
  logic [CONSTS_WID-1:0]   res_q;
  logic                    busy_q;
  logic                    arm_q;
  logic [IN_WID-1:0]       inp_q;
  logic [CONSTS_WID-1:0]   const_q;

  logic                    pick_vld_d;
  logic [GRANT_WID-1:0]    pick_idx_d;
  logic [GRANT_WID-1:0]    ptr_next_d;

  // Round-robin search: scan from the pointer downwards in priority so the
  // requester closest to the pointer (wrapping) is the last one written.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = GRANT_WID'(j);
      end
    end
  end

  // Pointer moves one past the winner so it ranks last in the next round.
  assign ptr_next_d = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + GRANT_WID'(1);

`ifdef MUL_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic        tmo_q;
`endif

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      arm_q    <= 1'b0;
      inp_q    <= '0;
      const_q  <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      wd_cnt_q <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // A multiplier still showing finished from a previous job is
          // not re-armed until it settles.
          if (!mul_finished && pick_vld_d) begin
            grant_q  <= pick_idx_d;
            inp_q    <= inp_flat[int'(pick_idx_d)*IN_WID +: IN_WID];
            const_q  <= const_flat[int'(pick_idx_d)*CONSTS_WID +: CONSTS_WID];
            arm_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_ARM;
`ifdef MUL_ARB_TIMEOUT_EN
            wd_cnt_q <= '0;
`endif
          end
        end
        ST_ARM: begin
          if (mul_finished) begin
            res_q   <= mul_outp;
            done_q  <= N_REQ'(1) << grant_q;
            arm_q   <= 1'b0;
            ptr_q   <= ptr_next_d;
            state_q <= ST_CLR;
`ifdef MUL_ARB_TIMEOUT_EN
          end else if (wd_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
            // Abort: no done pulse, res untouched, winner still loses its turn.
            arm_q   <= 1'b0;
            tmo_q   <= 1'b1;
            ptr_q   <= ptr_next_d;
            state_q <= ST_CLR;
          end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
`endif
          end
        end
        ST_CLR: begin
          if (!mul_finished) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          arm_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done         = done_q;
  assign res          = res_q;
  assign grant_idx    = grant_q;
  assign busy         = busy_q;
  assign mul_inp      = inp_q;
  assign mul_const_in = const_q;
  assign mul_arm      = arm_q;
  assign state_dbg    = state_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign timeout_err  = tmo_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mul_const_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_const_arbiter
//   Directed bench for mul_const_arbiter. A behavioural Q8.40 saturating
//   multiplier stands in for the external mul_const: it answers an arm with
//   the product after a fixed latency and holds finished until arm drops.
//   Expected products are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mul_const_arbiter;

  localparam int NR  = 3;
  localparam int GW  = 2;
  localparam int CW  = 48;
  localparam int IW  = 48;
  localparam int LAT = 3;
`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TCYC = 8;
`else
  localparam int TCYC = 256;
`endif

  // Q8.40 constants
  localparam logic [47:0] Q_0_5  = 48'h0080_0000_0000;
  localparam logic [47:0] Q_1_5  = 48'h0180_0000_0000;
  localparam logic [47:0] Q_2_0  = 48'h0200_0000_0000;
  localparam logic [47:0] Q_3_0  = 48'h0300_0000_0000;
  localparam logic [47:0] Q_4_0  = 48'h0400_0000_0000;
  localparam logic [47:0] Q_5_0  = 48'h0500_0000_0000;
  localparam logic [47:0] Q_M1_0 = 48'hFF00_0000_0000;
  localparam logic [47:0] Q_M3_0 = 48'hFD00_0000_0000;
  localparam logic [47:0] Q_100  = 48'h6400_0000_0000;
  localparam logic [47:0] Q_SATP = 48'h7FFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_L = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [NR*IW-1:0] inp_flat = '0;
  logic [NR*CW-1:0] const_flat = '0;
  logic [NR-1:0]    done;
  logic [CW-1:0]    res;
  logic [GW-1:0]    grant_idx;
  logic             busy;
  logic [IW-1:0]    mul_inp;
  logic [CW-1:0]    mul_const_in;
  logic             mul_arm;
  logic [CW-1:0]    mul_outp = '0;
  logic             mul_finished = 1'b0;
  logic             timeout_err;
  logic [1:0]       state_dbg;

  mul_const_arbiter #(
    .N_REQ(NR), .GRANT_WID(GW), .CONSTS_WID(CW), .IN_WID(IW), .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk(clk), .rst_L(rst_L), .req(req), .inp_flat(inp_flat), .const_flat(const_flat),
    .done(done), .res(res), .grant_idx(grant_idx), .busy(busy),
    .mul_inp(mul_inp), .mul_const_in(mul_const_in), .mul_arm(mul_arm),
    .mul_outp(mul_outp), .mul_finished(mul_finished),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- multiplier model ----------------
  function automatic logic [47:0] q_mul(input logic [47:0] a, input logic [47:0] b);
    logic signed [47:0] sa;
    logic signed [47:0] sb;
    logic signed [95:0] p;
    sa = a;
    sb = b;
    p  = sa * sb;
    p  = p >>> 40;
    if (p > 96'sh7FFF_FFFF_FFFF)        return 48'h7FFF_FFFF_FFFF;
    else if (p < -96'sh8000_0000_0000)  return 48'h8000_0000_0000;
    else                                return p[47:0];
  endfunction

  logic stub_dead = 1'b0;  // when set the multiplier never finishes
  int   lat_cnt = 0;
  always @(posedge clk) begin
    if (!mul_arm) begin
      mul_finished <= 1'b0;
      lat_cnt      <= 0;
    end else if (!mul_finished && !stub_dead) begin
      if (lat_cnt == LAT) begin
        mul_finished <= 1'b1;
        mul_outp     <= q_mul(mul_inp, mul_const_in);
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  logic [CW-1:0] exp_q[$];

  always @(negedge clk) if (done != '0) done_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [47:0] a, input logic [47:0] c);
    inp_flat[i*IW +: IW]   = a;
    const_flat[i*CW +: CW] = c;
  endtask

  // Wait (bounded) on negedges for a done pulse; leaves time at that negedge.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 60);
    check({tag, "_seen"}, 64'(done != '0), 64'(1));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    // ---- reset state ----
    #12;
    check("rst_done", 64'(done), 64'(0));
    check("rst_res", 64'(res), 64'(0));
    check("rst_arm", 64'(mul_arm), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);

    // ---- 1: single request, 2.0 * 1.5 ----
    set_op(0, Q_2_0, Q_1_5);
    req = 3'b001;
    @(posedge clk); #1;
    check("t1_arm", 64'(mul_arm), 64'(1));
    check("t1_grant", 64'(grant_idx), 64'(0));
    check("t1_inp", 64'(mul_inp), 64'(Q_2_0));
    check("t1_const", 64'(mul_const_in), 64'(Q_1_5));
    check("t1_busy", 64'(busy), 64'(1));
    req = 3'b000;
    wait_done("t1");
    check("t1_done", 64'(done), 64'(3'b001));
    check("t1_res", 64'(res), 64'(Q_3_0));
    @(negedge clk);
    check("t1_pulse", 64'(done), 64'(0));
    check("t1_hold", 64'(res), 64'(Q_3_0));
    wait_idle("t1");

    // ---- 2: req=111 held from reset, round robin ----
    rst_L = 1'b0;
    set_op(0, Q_2_0, Q_1_5);
    set_op(1, Q_0_5, Q_4_0);
    set_op(2, Q_M1_0, Q_3_0);
    req = 3'b111;
    exp_q = {Q_3_0, Q_2_0, Q_M3_0};
    @(negedge clk);
    rst_L = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_done($sformatf("t2_%0d", k));
      check($sformatf("t2_done_%0d", k), 64'(done), 64'(3'b001 << (k % 3)));
      check($sformatf("t2_grant_%0d", k), 64'(grant_idx), 64'(k % 3));
      check($sformatf("t2_res_%0d", k), 64'(res), 64'(exp_q[k % 3]));
    end
    req = 3'b000;
    wait_idle("t2");

    // ---- 3: saturation, 100.0 * 100.0 ----
    set_op(1, Q_100, Q_100);
    req = 3'b010;
    @(posedge clk); #1;
    check("t3_grant", 64'(grant_idx), 64'(1));
    req = 3'b000;
    wait_done("t3");
    check("t3_done", 64'(done), 64'(3'b010));
    check("t3_res", 64'(res), 64'(Q_SATP));
    wait_idle("t3");

    // ---- 4: operand changed after grant ----
    set_op(0, Q_2_0, Q_1_5);
    req = 3'b001;
    @(posedge clk); #1;
    req = 3'b000;
    set_op(0, Q_5_0, Q_1_5);
    @(negedge clk);
    check("t4_latched", 64'(mul_inp), 64'(Q_2_0));
    wait_done("t4");
    check("t4_done", 64'(done), 64'(3'b001));
    check("t4_res", 64'(res), 64'(Q_3_0));
    wait_idle("t4");

    // ---- 5: reset mid-ARM, then grant 1 ----
    set_op(2, Q_M1_0, Q_3_0);
    req = 3'b100;
    @(posedge clk); #1;
    req = 3'b000;
    check("t5_armed", 64'(mul_arm), 64'(1));
    check("t5_grant2", 64'(grant_idx), 64'(2));
    @(negedge clk);
    rst_L = 1'b0;
    #1;
    check("t5_arm_rst", 64'(mul_arm), 64'(0));
    check("t5_busy_rst", 64'(busy), 64'(0));
    check("t5_grant_rst", 64'(grant_idx), 64'(0));
    check("t5_res_rst", 64'(res), 64'(0));
    check("t5_inp_rst", 64'(mul_inp), 64'(0));
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    set_op(1, Q_0_5, Q_4_0);
    req = 3'b010;
    @(posedge clk); #1;
    check("t5_grant1", 64'(grant_idx), 64'(1));
    req = 3'b000;
    wait_done("t5");
    check("t5_done", 64'(done), 64'(3'b010));
    check("t5_res", 64'(res), 64'(Q_2_0));
    wait_idle("t5");
    check("tmo_flag_clear", 64'(timeout_err), 64'(0));

`ifdef MUL_ARB_TIMEOUT_EN
    // ---- 6: watchdog with a dead multiplier ----
    begin
      int arm_cycles;
      int seen_before;
      arm_cycles  = 0;
      seen_before = done_seen;
      stub_dead   = 1'b1;
      req = 3'b001;
      @(posedge clk); #1;
      req = 3'b000;
      while (mul_arm && arm_cycles < 60) begin
        arm_cycles++;
        @(posedge clk); #1;
      end
      check("t6_arm_cycles", 64'(arm_cycles), 64'(TCYC));
      check("t6_tmo", 64'(timeout_err), 64'(1));
      wait_idle("t6");
      check("t6_no_done", 64'(done_seen - seen_before), 64'(0));
      check("t6_res_kept", 64'(res), 64'(Q_2_0));
      check("t6_sticky", 64'(timeout_err), 64'(1));
      stub_dead = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "global timeout");
  end

endmodule
